// File: rtl/mem_responder_pkg.sv
// ============================================================================
// Module   : mem_responder_pkg
// Purpose  : Shared constants, state and operation encodings for the memory
//            responder, control unit and datapath bench.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_responder_pkg;

  // Default geometry shared with the control unit and datapath
  localparam int unsigned MEM_ADDR_W      = 9;
  localparam int unsigned MEM_DATA_W      = 32;
  localparam int unsigned MEM_DEPTH       = 512;
  localparam int unsigned MEM_WAIT_CYCLES = 2;
  localparam int unsigned MEM_PROT_LIMIT  = 16;

  // Wait-state counter width; WAIT_CYCLES is limited to 0..15
  localparam int unsigned MEM_CNT_W = 4;

  // Handshake FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_ACK     = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  // Operation captured at the start of an access
  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_ERR   = 2'd2
  } op_e;

  // Both strobes high is an illegal request and is carried as an error op
  function automatic op_e decode_op(input logic rd, input logic wr);
    op_e op;
    op = OP_READ;
    if (rd && wr) begin
      op = OP_ERR;
    end else if (wr) begin
      op = OP_WRITE;
    end
    return op;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_responder_array.sv
// ============================================================================
// Module   : mem_array
// Purpose  : Single-port RAM, DEPTH x DATA_W, synchronous write and a
//            combinational read port. Not reset. Kept separate from the
//            handshake logic so a vendor macro can replace it.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_array #(
  parameter int unsigned IDX_W  = 9,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 512
) (
  input  logic              clock,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Commit a write on the clock edge when enabled
  always_ff @(posedge clock) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

`default_nettype wire

// File: rtl/mem_responder.sv
// ============================================================================
// Module   : mem_responder
// Purpose  : Word-addressed memory responder on the CPU four-phase memory
//            handshake. Captures a Read/Write request, inserts WAIT_CYCLES
//            wait states, performs the access, pulses Done (and err on a
//            bad request) and waits for the request to drop.
// Options  : MEM_WRITE_PROTECT_EN - when defined, writes below PROT_LIMIT are
//            suppressed and reported with err.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_W      = MEM_ADDR_W,
  parameter int unsigned DATA_W      = MEM_DATA_W,
  parameter int unsigned DEPTH       = MEM_DEPTH,
  parameter int unsigned WAIT_CYCLES = MEM_WAIT_CYCLES,
  parameter int unsigned PROT_LIMIT  = MEM_PROT_LIMIT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              Read,
  input  logic              Write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              Done,
  output logic              busy,
  output logic              err
);

  localparam int unsigned          c_IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam bit                   c_NO_WAIT   = (WAIT_CYCLES == 0);
  localparam logic [MEM_CNT_W-1:0] c_WAIT_LOAD = MEM_CNT_W'(WAIT_CYCLES - 1);
`ifdef MEM_WRITE_PROTECT_EN
  localparam bit                   c_PROT_EN   = 1'b1;
`else
  localparam bit                   c_PROT_EN   = 1'b0;
`endif

  state_e                 state_q;
  logic [MEM_CNT_W-1:0]   cnt_q;
  op_e                    op_q;
  logic [ADDR_W-1:0]      addr_q;
  logic [DATA_W-1:0]      wdata_q;
  logic [DATA_W-1:0]      rdata_q;
  logic                   done_q;
  logic                   busy_q;
  logic                   err_q;

  logic                   w_req;
  op_e                    w_req_op;
  op_e                    w_acc_op;
  logic [ADDR_W-1:0]      w_acc_addr;
  logic [DATA_W-1:0]      w_acc_wdata;
  logic                   w_enter_ack;
  logic                   w_in_range;
  logic                   w_protected;
  logic                   w_acc_err;
  logic                   w_ram_we;
  logic [c_IDX_W-1:0]     w_ram_addr;
  logic [DATA_W-1:0]      w_ram_rdata;

  assign w_req    = Read || Write;
  assign w_req_op = decode_op(Read, Write);

  // With zero wait states the access happens on the capture edge itself, so
  // the live request is used in IDLE and the latched copy everywhere else.
  assign w_acc_op    = (state_q == ST_IDLE) ? w_req_op : op_q;
  assign w_acc_addr  = (state_q == ST_IDLE) ? addr     : addr_q;
  assign w_acc_wdata = (state_q == ST_IDLE) ? wdata    : wdata_q;

  assign w_enter_ack = ((state_q == ST_IDLE) && w_req && c_NO_WAIT) ||
                       ((state_q == ST_WAIT) && (cnt_q == '0));

  assign w_in_range  = (32'(w_acc_addr) < DEPTH);
  assign w_protected = c_PROT_EN && (w_acc_op == OP_WRITE) &&
                       (32'(w_acc_addr) < PROT_LIMIT);
  assign w_acc_err   = (w_acc_op == OP_ERR) || !w_in_range || w_protected;
  assign w_ram_we    = w_enter_ack && (w_acc_op == OP_WRITE) && !w_acc_err;
  assign w_ram_addr  = w_acc_addr[c_IDX_W-1:0];

  mem_array #(
    .IDX_W  (c_IDX_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem_array (
    .clock   (clock),
    .we_i    (w_ram_we),
    .addr_i  (w_ram_addr),
    .wdata_i (w_acc_wdata),
    .rdata_o (w_ram_rdata)
  );

  // Handshake FSM with registered Done/err/busy/rdata; reset aborts any access
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_READ;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;

      if (w_enter_ack) begin
        done_q <= 1'b1;
        err_q  <= w_acc_err;
        if ((w_acc_op == OP_READ) && !w_acc_err) begin
          rdata_q <= w_ram_rdata;
        end
      end

      case (state_q)
        ST_IDLE: begin
          if (w_req) begin
            op_q    <= w_req_op;
            addr_q  <= addr;
            wdata_q <= wdata;
            busy_q  <= 1'b1;
            if (c_NO_WAIT) begin
              state_q <= ST_ACK;
            end else begin
              state_q <= ST_WAIT;
              cnt_q   <= c_WAIT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == '0) begin
            state_q <= ST_ACK;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_ACK: begin
          state_q <= ST_RELEASE;
        end
        ST_RELEASE: begin
          if (!w_req) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign rdata = rdata_q;
  assign Done  = done_q;
  assign busy  = busy_q;
  assign err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// ============================================================================
// Module   : tb_mem_responder
// Purpose  : Scoreboard bench for mem_responder (DEPTH=256 so out-of-range
//            addresses exist). Honours MEM_WRITE_PROTECT_EN in its model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_responder;

  localparam int W     = 2;
  localparam int DEPTH = 256;
  localparam int PROT  = 16;
`ifdef MEM_WRITE_PROTECT_EN
  localparam bit PROT_EN = 1'b1;
`else
  localparam bit PROT_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        Read;
  logic        Write;
  logic [8:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        Done;
  logic        busy;
  logic        err;

  mem_responder #(
    .ADDR_W      (9),
    .DATA_W      (32),
    .DEPTH       (DEPTH),
    .WAIT_CYCLES (W),
    .PROT_LIMIT  (PROT)
  ) u_dut (
    .clock (clock),
    .reset (reset),
    .Read  (Read),
    .Write (Write),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .Done  (Done),
    .busy  (busy),
    .err   (err)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] mdl_mem [int];
  logic [31:0] mdl_rdata;
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_done   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: applies the access rules and records the expected response
  task automatic model_access(input logic rd, input logic wr, input logic [8:0] a,
                              input logic [31:0] d);
    exp_t e;
    bit   bad;
    bad = (rd && wr) || (int'(a) >= DEPTH) || (wr && PROT_EN && (int'(a) < PROT));
    if (!bad) begin
      if (wr) mdl_mem[int'(a)] = d;
      else    mdl_rdata = mdl_mem[int'(a)];
    end
    e.rdata = mdl_rdata;
    e.err   = bad;
    sb_q.push_back(e);
  endtask

  // Monitor: every Done pulse is matched against the oldest expectation
  always @(negedge clock) begin
    exp_t e;
    if (!reset && Done === 1'b1) begin
      n_done++;
      if (sb_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        check("rdata", 64'(rdata), 64'(e.rdata));
        check("err", 64'(err), 64'(e.err));
      end
    end
  end

  // Full four-phase access; request held for 'hold' extra cycles after Done
  task automatic access(input logic rd, input logic wr, input logic [8:0] a,
                        input logic [31:0] d, input int hold);
    int n;
    int done0;
    bit seen;
    bit bad_busy;
    model_access(rd, wr, a, d);
    @(negedge clock);
    Read = rd; Write = wr; addr = a; wdata = d;
    done0 = n_done;
    @(posedge clock);
    #2;
    addr  = 9'($urandom);
    wdata = $urandom;
    seen  = 1'b0;
    for (n = 1; n <= 40; n++) begin
      #1;
      if (Done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(posedge clock);
    end
    check("done_latency", seen ? 64'(n) : 64'd0, 64'(W + 1));
    bad_busy = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clock);
      #1;
      if (busy !== 1'b1) bad_busy = 1'b1;
      #2;
      if ($urandom_range(0, 1) == 1) begin
        Read  = 1'($urandom_range(0, 1));
        Write = !Read || ($urandom_range(0, 3) == 0);
      end
    end
    check("busy_hold", 64'(bad_busy), 64'd0);
    @(negedge clock);
    Read = 1'b0; Write = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;
    check("busy_release", 64'(busy), 64'd0);
    check("done_count", 64'(n_done - done0), 64'd1);
  endtask

  // Write interrupted by reset while in WAIT; nothing may be committed
  task automatic reset_abort(input logic [8:0] a, input logic [31:0] d);
    @(negedge clock);
    Read = 1'b0; Write = 1'b1; addr = a; wdata = d;
    @(posedge clock);
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("reset_abort_outputs", {rdata, Done, busy, err}, 64'd0);
    @(negedge clock);
    Write = 1'b0;
    reset = 1'b0;
    mdl_rdata = '0;
    @(posedge clock);
    #1;
    check("reset_abort_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0]  pool [8];
    logic [8:0]  a;
    logic        rd;
    logic        wr;
    int          sel;

    pool[0] = 9'h000; pool[1] = 9'h00F; pool[2] = 9'h010; pool[3] = 9'h020;
    pool[4] = 9'h05A; pool[5] = 9'h0FF; pool[6] = 9'h100; pool[7] = 9'h1FF;

    reset = 1'b1; Read = 1'b0; Write = 1'b0; addr = '0; wdata = '0;
    mdl_rdata = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_state", {rdata, Done, busy, err}, 64'd0);
    @(negedge clock);
    reset = 1'b0;

    // Write then read back
    access(1'b0, 1'b1, 9'h05A, 32'hDEADBEEF, 0);
    access(1'b1, 1'b0, 9'h05A, 32'h0, 0);
    // Request held long after Done
    access(1'b1, 1'b0, 9'h05A, 32'h0, 10);
    // Top word in range, first and last out-of-range words
    access(1'b0, 1'b1, 9'h0FF, 32'h00000001, 0);
    access(1'b1, 1'b0, 9'h0FF, 32'h0, 0);
    access(1'b1, 1'b0, 9'h100, 32'h0, 0);
    access(1'b0, 1'b1, 9'h1FF, 32'h55555555, 0);
    // Both strobes together must not touch memory or rdata
    access(1'b1, 1'b1, 9'h05A, 32'h0BADF00D, 0);
    access(1'b1, 1'b0, 9'h05A, 32'h0, 0);
    // Reset during a write loses the write
    access(1'b0, 1'b1, 9'h020, 32'hAAAAAAAA, 0);
    reset_abort(9'h020, 32'h12345678);
    access(1'b1, 1'b0, 9'h020, 32'h0, 0);
    // Protection boundary
    access(1'b0, 1'b1, 9'h00F, 32'hFFFFFFFF, 0);
    access(1'b0, 1'b1, 9'h010, 32'hC0FFEE01, 0);
    access(1'b1, 1'b0, 9'h010, 32'h0, 0);
    if (mdl_mem.exists(15)) access(1'b1, 1'b0, 9'h00F, 32'h0, 0);

    // Randomized traffic
    for (int k = 0; k < 40; k++) begin
      a   = ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 7)] : 9'($urandom);
      sel = int'($urandom_range(0, 19));
      rd  = (sel < 9) || (sel >= 18);
      wr  = (sel >= 9);
      if (rd && !wr && (int'(a) < DEPTH) && !mdl_mem.exists(int'(a))) begin
        rd = 1'b0;
        wr = 1'b1;
      end
      access(rd, wr, a, $urandom, int'($urandom_range(0, 3)));
    end

    repeat (4) @(posedge clock);
    #1;
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
